// File: rtl/xor_chk_pkg.sv
// Shared definitions for the XOR response checker: FSM state encoding and
// the saturating counter increment used by every counter in the checker.
package xor_chk_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } chk_state_e;

  // Widest counter the helper supports; callers zero-extend into it.
  localparam int unsigned SAT_W = 64;

  // Returns value+1, or holds at the all-ones value of a width-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input int unsigned      width);
    logic [SAT_W-1:0] max_v;
    max_v = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
    return (value >= max_v) ? max_v : value + SAT_W'(1);
  endfunction

endpackage : xor_chk_pkg

// File: rtl/xor_response_checker_syndrome_stage.sv
// First pipeline stage of the checker: folds each accepted beat into a
// syndrome (operand A ^ operand B ^ DUT result) plus its valid flag.
module xor_syndrome_stage #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             accept_i,
  input  logic [WIDTH-1:0] input1_i,
  input  logic [WIDTH-1:0] input2_i,
  input  logic [WIDTH-1:0] dut_out_i,
  output logic [WIDTH-1:0] syn_o,
  output logic             v1_o
);

  logic [WIDTH-1:0] syn_q;
  logic             v1_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      v1_q  <= 1'b0;
      // NOTE: the syndrome is cleared too, so nothing downstream can ever
      // observe X even if a consumer forgets to qualify it with v1.
      syn_q <= '0;
    end else begin
      v1_q <= accept_i;
      if (accept_i) begin
        syn_q <= input1_i ^ input2_i ^ dut_out_i;
      end
    end
  end

  assign syn_o = syn_q;
  assign v1_o  = v1_q;

endmodule : xor_syndrome_stage

// File: rtl/xor_response_checker.sv
// Consumer end of the XOR stimulus stream: recomputes input1^input2, scores
// each beat against dut_out, keeps saturating counters and the first failure.
module xor_response_checker #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             stop_on_fail,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] dut_out,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_syn,
  output logic             halted
);

  import xor_chk_pkg::*;

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             fail_seen_q, fail_seen_d;
  logic [CNT_W-1:0] ffail_idx_q, ffail_idx_d;
  logic [WIDTH-1:0] ffail_syn_q, ffail_syn_d;

  logic             accept;
  logic [WIDTH-1:0] syn;
  logic             v1;
  logic             score_pass;
  logic             score_fail;

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;

  xor_syndrome_stage #(
    .WIDTH (WIDTH)
  ) u_syn_stage (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .accept_i  (accept),
    .input1_i  (input1),
    .input2_i  (input2),
    .dut_out_i (dut_out),
    .syn_o     (syn),
    .v1_o      (v1)
  );

  assign score_pass = v1 && (syn == '0);
  assign score_fail = v1 && (syn != '0);

  // NOTE: every signal written here gets its default first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_seen_d = fail_seen_q;
    ffail_idx_d = ffail_idx_q;
    ffail_syn_d = ffail_syn_q;

    if (v1) begin
      beat_cnt_d = CNT_W'(sat_inc(SAT_W'(beat_cnt_q), CNT_W));
    end
    if (score_pass) begin
      pass_cnt_d = CNT_W'(sat_inc(SAT_W'(pass_cnt_q), CNT_W));
    end
    if (score_fail) begin
      fail_cnt_d = CNT_W'(sat_inc(SAT_W'(fail_cnt_q), CNT_W));
      // The capture index is the pre-increment beat count, i.e. 0-based.
      if (!fail_seen_q) begin
        fail_seen_d = 1'b1;
        ffail_idx_d = beat_cnt_q;
        ffail_syn_d = syn;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (score_fail && stop_on_fail) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= ST_RUN;
      beat_cnt_q  <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_seen_q <= 1'b0;
      ffail_idx_q <= '0;
      ffail_syn_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_seen_q <= fail_seen_d;
      ffail_idx_q <= ffail_idx_d;
      ffail_syn_q <= ffail_syn_d;
    end
  end

  assign beat_cnt       = beat_cnt_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign fail_seen      = fail_seen_q;
  assign first_fail_idx = ffail_idx_q;
  assign first_fail_syn = ffail_syn_q;
  assign halted         = (state_q == ST_HALT);

endmodule : xor_response_checker

// File: tb/tb_xor_response_checker.sv
// Directed-plus-random bench for xor_response_checker, scored against a
// counting reference model of the checker's observable behaviour.
module tb_xor_response_checker;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 32;
  localparam longint      CMAX  = 64'h0000_0000_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             stop_on_fail = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] input1 = '0;
  logic [WIDTH-1:0] input2 = '0;
  logic [WIDTH-1:0] dut_out = '0;
  logic [CNT_W-1:0] beat_cnt, pass_cnt, fail_cnt, first_fail_idx;
  logic             fail_seen, halted;
  logic [WIDTH-1:0] first_fail_syn;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the checker should report.
  longint           m_beat, m_pass, m_fail, m_idx;
  bit               m_seen;
  logic [WIDTH-1:0] m_syn;

  xor_response_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .stop_on_fail   (stop_on_fail),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .input1         (input1),
    .input2         (input2),
    .dut_out        (dut_out),
    .beat_cnt       (beat_cnt),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .fail_seen      (fail_seen),
    .first_fail_idx (first_fail_idx),
    .first_fail_syn (first_fail_syn),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_beat = 0; m_pass = 0; m_fail = 0; m_idx = 0; m_seen = 1'b0; m_syn = '0;
  endtask

  // A beat is good exactly when the DUT result equals the XOR of the operands.
  task automatic model_score(input logic [63:0] a, input logic [63:0] b, input logic [63:0] o);
    if (o == (a ^ b)) begin
      m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
    end else begin
      m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
      if (!m_seen) begin
        m_seen = 1'b1;
        m_idx  = m_beat;
        m_syn  = a ^ b ^ o;
      end
    end
    m_beat = (m_beat < CMAX) ? m_beat + 1 : CMAX;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_beat"}, 64'(beat_cnt), 64'(m_beat));
    check({tag, "_pass"}, 64'(pass_cnt), 64'(m_pass));
    check({tag, "_fail"}, 64'(fail_cnt), 64'(m_fail));
    check({tag, "_seen"}, 64'(fail_seen), 64'(m_seen));
    check({tag, "_idx"},  64'(first_fail_idx), 64'(m_idx));
    check({tag, "_syn"},  first_fail_syn, m_syn);
  endtask

  // Present one beat for one cycle; acc reports whether it was taken.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] o,
                      output bit acc);
    in_valid = 1'b1; input1 = a; input2 = b; dut_out = o;
    acc = in_ready;
    if (acc) model_score(a, b, o);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [79:0]  i;
    logic [63:0]  a, b, o;
    bit           acc;
    int           acc_cnt;
    bit           rst_now;

    model_reset();
    @(negedge clk);
    do_reset();
    check("reset_ready",  64'(in_ready), 64'd1);
    check("reset_halted", 64'(halted),   64'd0);
    check_all("reset");

    // 1: long run of correct results.
    i = '0;
    for (int k = 0; k < 1000; k++) begin
      a = i[63:0]; b = i[75:12];
      send(a, b, a ^ b, acc);
      i = i + 80'd1000000;
    end
    idle(3);
    check_all("t1");
    check("t1_pass_abs", 64'(pass_cnt), 64'd1000);

    // 2: two corruptions, no stop; the first one is captured.
    do_reset();
    stop_on_fail = 1'b0;
    for (int k = 0; k < 12; k++) begin
      a = rnd64(); b = rnd64();
      o = a ^ b ^ ((k == 5) ? 64'h8 : (k == 9) ? 64'h1 : 64'h0);
      send(a, b, o, acc);
    end
    idle(3);
    check_all("t2");
    check("t2_idx_abs", 64'(first_fail_idx), 64'd5);
    check("t2_syn_abs", first_fail_syn, 64'h8);
    check("t2_halted",  64'(halted), 64'd0);

    // 3: stop on fail with continuous valid; one trailing beat still drains.
    do_reset();
    stop_on_fail = 1'b1;
    acc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      a = rnd64(); b = rnd64();
      send(a, b, a ^ b ^ ((k == 2) ? 64'h10 : 64'h0), acc);
      acc_cnt += int'(acc);
      if (k == 2) check("t3_not_halted_yet", 64'(halted), 64'd0);
      if (k == 3) begin
        check("t3_halted",   64'(halted),   64'd1);
        check("t3_in_ready", 64'(in_ready), 64'd0);
      end
    end
    idle(3);
    check("t3_accepted", 64'(acc_cnt), 64'd4);
    check_all("t3");
    stop_on_fail = 1'b0;
    idle(3);
    check("t3_still_halted", 64'(halted), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check("t3_clear_run",   64'(halted),   64'd0);
    check("t3_clear_ready", 64'(in_ready), 64'd1);

    // 4: counters preloaded just below saturation.
    do_reset();
    force dut.beat_cnt_q = 32'hFFFF_FFFE;
    force dut.pass_cnt_q = 32'hFFFF_FFFE;
    force dut.fail_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.beat_cnt_q;
    release dut.pass_cnt_q;
    release dut.fail_cnt_q;
    m_beat = 64'hFFFF_FFFE; m_pass = 64'hFFFF_FFFE; m_fail = 64'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      a = rnd64(); b = rnd64();
      send(a, b, a ^ b, acc);
    end
    idle(3);
    check_all("t4");
    check("t4_pass_sat", 64'(pass_cnt), 64'hFFFF_FFFF);
    a = rnd64(); b = rnd64();
    send(a, b, a ^ b ^ 64'h80, acc);
    idle(3);
    check_all("t4_late_fail");

    // 5: clear coincides with an accepted corrupt beat while another is in S1.
    do_reset();
    stop_on_fail = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a = rnd64(); b = rnd64();
      send(a, b, a ^ b ^ ((k == 3) ? 64'h2 : 64'h0), acc);
    end
    check("t5_pre_seen", 64'(fail_seen), 64'd1);
    in_valid = 1'b1; input1 = rnd64(); input2 = rnd64(); dut_out = input1 ^ input2 ^ 64'h4;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check_all("t5_clear");
    check("t5_halted",  64'(halted),   64'd0);
    check("t5_ready",   64'(in_ready), 64'd1);
    idle(3);
    check_all("t5_drained");

    // 6: random valid with a reset in the middle of the stream.
    do_reset();
    for (int c = 0; c < 120; c++) begin
      rst_now  = (c == 60);
      rst      = rst_now;
      in_valid = 1'($urandom_range(0, 1));
      a = rnd64(); b = rnd64();
      input1 = a; input2 = b; dut_out = a ^ b;
      acc = in_valid && in_ready;
      @(negedge clk);
      if (rst_now) model_reset();
      else if (acc) model_score(a, b, a ^ b);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    idle(3);
    check_all("t6");
    check("t6_no_x", 64'($isunknown({in_ready, beat_cnt, pass_cnt, fail_cnt, fail_seen,
                                     first_fail_idx, first_fail_syn, halted})), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_xor_response_checker
